// File: rtl/barrel_shifter_rotate_right_seq_if.sv
// Handshake bundle for the sequential right-rotate / arithmetic-shift unit.
// The producer/consumer side uses the master modport; the shifter uses slave.
interface barrel_shifter_rotate_right_seq_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shift_amount;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, shift_amount, mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, shift_amount, mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shifter_rotate_right_seq.sv
// Sequential barrel shifter: rotate right (mode 0) or arithmetic shift
// right (mode 1), one log-stage per clock (8, 4, 2, 1 for WIDTH=16).
// WIDTH must be a power of two and SHW must equal log2(WIDTH).
// Optional macro ROTR_ZERO_BYPASS_EN: a zero shift amount jumps straight
// to DONE on the accepting edge instead of walking through every stage.
module barrel_shifter_rotate_right_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    barrel_shifter_rotate_right_seq_if.slave  bus
);

    localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [SHW:0] WIDTH_L = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  work_q;
    logic [SHW-1:0]    amount_q;
    logic              mode_q;
    logic [KW-1:0]     stage_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;
    logic              in_ready_q;

    logic [SHW:0]              stepAmt;
    logic signed [WIDTH-1:0]   workSigned;
    logic [WIDTH-1:0]          work_d;

    // One shifter stage: distance 2^stage, applied only when that amount bit is set.
    always_comb begin
        stepAmt    = (SHW+1)'(1) << stage_q;
        workSigned = $signed(work_q);
        work_d     = work_q;
        if (amount_q[stage_q]) begin
            if (mode_q) begin
                work_d = workSigned >>> stepAmt;
            end else begin
                work_d = (work_q >> stepAmt) | (work_q << (WIDTH_L - stepAmt));
            end
        end
    end

    // Handshake FSM with registered in_ready/out_valid/out_data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            amount_q    <= '0;
            mode_q      <= 1'b0;
            stage_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.in_data;
                        amount_q   <= bus.shift_amount;
                        mode_q     <= bus.mode;
                        stage_q    <= KW'(SHW - 1);
                        in_ready_q <= 1'b0;
`ifdef ROTR_ZERO_BYPASS_EN
                        if (bus.shift_amount == '0) begin
                            out_data_q  <= bus.in_data;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
`else
                        state_q <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    if (stage_q == '0) begin
                        out_data_q  <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        stage_q <= stage_q - KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_barrel_shifter_rotate_right_seq.sv
// Self-checking bench for barrel_shifter_rotate_right_seq: directed cases
// plus randomized transactions, all checked against a transaction-level
// reference model. Honours ROTR_ZERO_BYPASS_EN for the expected latency.
module tb_barrel_shifter_rotate_right_seq;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;
`ifdef ROTR_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    barrel_shifter_rotate_right_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    barrel_shifter_rotate_right_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nCompared   = 0;
    int nMismatched = 0;
    bit checkEn     = 1'b0;
    bit randReady   = 1'b0;

    int               mPhase   = 0;
    int               mCount   = 0;
    logic [WIDTH-1:0] mPending = '0;
    logic [WIDTH-1:0] mOutData = '0;
    logic [WIDTH-1:0] mRes;

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] refModel(input logic [WIDTH-1:0] d, input int n, input bit m);
        int u;
        int s;
        int r;
        u = int'(d);
        if (!m) begin
            r = ((u >> n) | (u << (WIDTH - n))) & ((1 << WIDTH) - 1);
        end else begin
            s = d[WIDTH-1] ? (u - (1 << WIDTH)) : u;
            r = (s >>> n) & ((1 << WIDTH) - 1);
        end
        return WIDTH'(r);
    endfunction

    function automatic int expLatency(input int amt);
        return (BYPASS && amt == 0) ? 0 : SHW;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: idle, busy for a fixed number of edges, then holding a result.
    always @(posedge clk) begin
        if (!rst_n) begin
            mPhase   = 0;
            mOutData = '0;
        end else begin
            case (mPhase)
                0: if (bus.in_valid) begin
                    mRes = refModel(bus.in_data, int'(bus.shift_amount), bus.mode);
                    if (BYPASS && bus.shift_amount == '0) begin
                        mOutData = mRes;
                        mPhase   = 2;
                    end else begin
                        mPending = mRes;
                        mCount   = SHW;
                        mPhase   = 1;
                    end
                end
                1: begin
                    mCount--;
                    if (mCount == 0) begin
                        mOutData = mPending;
                        mPhase   = 2;
                    end
                end
                default: if (bus.out_ready) mPhase = 0;
            endcase
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model in_ready",  WIDTH'(bus.in_ready),  WIDTH'(mPhase == 0));
            checkOutput("model out_valid", WIDTH'(bus.out_valid), WIDTH'(mPhase == 2));
            checkOutput("model out_data",  bus.out_data,          mOutData);
        end
    end

    task automatic tick();
        @(negedge clk);
        if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt, input bit m);
        int w = 0;
        while (!bus.in_ready && w < 60) begin
            tick();
            w++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept timeout", WIDTH'(bus.in_ready), WIDTH'(1));
            return;
        end
        bus.in_data      = d;
        bus.shift_amount = amt;
        bus.mode         = m;
        bus.in_valid     = 1'b1;
        tick();
        bus.in_valid     = 1'b0;
        bus.in_data      = WIDTH'($urandom);
        bus.shift_amount = SHW'($urandom);
        bus.mode         = 1'($urandom_range(0, 1));
    endtask

    task automatic waitResult(input string name, input logic [WIDTH-1:0] expData, input int expLat);
        int cnt = 0;
        while (!bus.out_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        checkOutput({name, " latency"}, WIDTH'(cnt), WIDTH'(expLat));
        checkOutput({name, " data"}, bus.out_data, expData);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.shift_amount = '0;
        bus.mode         = 1'b0;
        bus.out_ready    = 1'b1;
        rst_n            = 1'b0;

        checkOutput("pin rotr 0x1234>>4",  refModel(16'h1234, 4, 1'b0), 16'h4123);
        checkOutput("pin rotr 0xABCD>>15", refModel(16'hABCD, 15, 1'b0), 16'h579B);
        checkOutput("pin asr 0xF0F0>>4",   refModel(16'hF0F0, 4, 1'b1), 16'hFF0F);

        @(posedge clk);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset in_ready",  WIDTH'(bus.in_ready),  WIDTH'(1));
        checkOutput("reset out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
        checkOutput("reset out_data",  bus.out_data, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic rotations and arithmetic shifts with out_ready held high.
        applyStimulus(16'h1234, 4'd4, 1'b0);
        waitResult("t1 rotr", 16'h4123, SHW);
        tick();
        checkOutput("t1 back to idle", WIDTH'(bus.in_ready), WIDTH'(1));
        applyStimulus(16'h8001, 4'd1, 1'b0);
        waitResult("t2 rotr 1", 16'hC000, SHW);
        applyStimulus(16'hABCD, 4'd15, 1'b0);
        waitResult("t2 rotr 15", 16'h579B, SHW);
        applyStimulus(16'h8000, 4'd15, 1'b1);
        waitResult("t3 asr 15", 16'hFFFF, SHW);
        applyStimulus(16'h4000, 4'd14, 1'b1);
        waitResult("t3 asr 14", 16'h0001, SHW);
        applyStimulus(16'hF0F0, 4'd4, 1'b1);
        waitResult("t3 asr 4", 16'hFF0F, SHW);
        applyStimulus(16'hABCD, 4'd0, 1'b0);
        waitResult("t6 zero amount", 16'hABCD, expLatency(0));

        // Backpressure: result held while new input waits outside IDLE.
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(16'h1234, 4'd4, 1'b0);
        waitResult("t4 bp result", 16'h4123, SHW);
        bus.in_data      = 16'h00F0;
        bus.shift_amount = 4'd4;
        bus.mode         = 1'b1;
        bus.in_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t4 bp hold data", bus.out_data, 16'h4123);
            checkOutput("t4 bp in_ready", WIDTH'(bus.in_ready), WIDTH'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        checkOutput("t4 handshake done", WIDTH'(bus.out_valid), WIDTH'(0));
        tick();
        bus.in_valid = 1'b0;
        checkOutput("t4 new accepted", WIDTH'(bus.in_ready), WIDTH'(0));
        waitResult("t4 new result", 16'h000F, SHW);

        // Reset while the shifter is at stage 2.
        applyStimulus(16'hABCD, 4'd3, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t5 reset out_valid", WIDTH'(bus.out_valid), WIDTH'(0));
        checkOutput("t5 reset out_data",  bus.out_data, 16'h0000);
        checkOutput("t5 reset in_ready",  WIDTH'(bus.in_ready), WIDTH'(1));
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("t5 no late result", WIDTH'(bus.out_valid), WIDTH'(0));
        end

        // Randomized transactions with random consumer backpressure.
        randReady = 1'b1;
        for (int t = 0; t < 150; t++) begin
            logic [WIDTH-1:0] d;
            logic [SHW-1:0]   a;
            bit               m;
            d = WIDTH'($urandom);
            a = SHW'($urandom);
            m = 1'($urandom_range(0, 1));
            if (t % 10 == 0) a = '0;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            applyStimulus(d, a, m);
            waitResult("rand", refModel(d, int'(a), m), expLatency(int'(a)));
        end
        randReady     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
